// File: rtl/ahbl_slave_decoder.sv
// ahbl_slave_decoder: AHB-Lite address decoder, data-phase response mux and default ERROR slave.
// Optional feature: define AHBL_DEC_ERR_CNT_EN to add the saturating DEC_ERR_COUNT output.
module ahbl_slave_decoder #(
    parameter int NS = 4,
    parameter logic [NS*32-1:0] SLAVE_BASE = {NS{32'h0}},
    parameter logic [NS*32-1:0] SLAVE_MASK = {NS{32'h0}}
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    output logic [NS-1:0]    HSEL,
    input  logic [NS-1:0]    HREADYOUT_S,
    input  logic [NS-1:0]    HRESP_S,
    input  logic [NS*32-1:0] HRDATA_S,
    output logic             HREADY,
    output logic             HRESP,
`ifdef AHBL_DEC_ERR_CNT_EN
    output logic [31:0]      HRDATA,
    output logic [15:0]      DEC_ERR_COUNT
`else
    output logic [31:0]      HRDATA
`endif
);
    typedef enum logic [1:0] {DS_OK, DS_ERR1, DS_ERR2} ds_e;

    ds_e ds_q, ds_d;
    logic [NS-1:0] dsel_q, dsel_d;
    logic ddef_q, ddef_d;
    logic hit, act, def_ready, def_resp, err_start;

    assign act = HTRANS inside {2'b10, 2'b11};
    assign err_start = HREADY && !hit && act;
    assign def_ready = ds_q != DS_ERR1;
    assign def_resp = ds_q != DS_OK;
    assign dsel_d = HREADY ? HSEL : dsel_q;
    assign ddef_d = HREADY ? !hit : ddef_q;

    // Address decode: first (lowest-index) matching region wins, so HSEL stays one-hot
    always_comb begin
        HSEL = '0;
        hit = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (!hit && (HADDR & SLAVE_MASK[i*32+:32]) == SLAVE_BASE[i*32+:32]) begin
                HSEL[i] = 1'b1;
                hit = 1'b1;
            end
        end
    end

    // Data-phase mux: registered selection picks the responding slave, default slave returns zero data
    always_comb begin
        HREADY = ddef_q & def_ready;
        HRESP = ddef_q & def_resp;
        HRDATA = '0;
        for (int i = 0; i < NS; i++) begin
            if (dsel_q[i]) begin
                HREADY = HREADYOUT_S[i];
                HRESP = HRESP_S[i];
                HRDATA = HRDATA_S[i*32+:32];
            end
        end
    end

    // Default slave next state: active unmapped transfer starts the two-cycle ERROR response
    always_comb begin
        ds_d = ds_q;
        case (ds_q)
            DS_OK:   ds_d = err_start ? DS_ERR1 : DS_OK;
            DS_ERR1: ds_d = DS_ERR2;
            DS_ERR2: ds_d = err_start ? DS_ERR1 : DS_OK;
            default: ds_d = DS_OK;
        endcase
    end

    // Data-phase select and default-slave state; selection only advances on accepted address phases
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dsel_q <= '0;
            ddef_q <= 1'b1;
            ds_q <= DS_OK;
        end else begin
            dsel_q <= dsel_d;
            ddef_q <= ddef_d;
            ds_q <= ds_d;
        end
    end

`ifdef AHBL_DEC_ERR_CNT_EN
    logic [15:0] cnt_q;

    // Decode-error counter: one count per entry into DS_ERR1, saturating
    always_ff @(posedge HCLK) begin
        if (HRESET)
            cnt_q <= '0;
        else if (ds_d == DS_ERR1 && ds_q != DS_ERR1 && cnt_q != 16'hFFFF)
            cnt_q <= cnt_q + 16'd1;
    end

    assign DEC_ERR_COUNT = cnt_q;
`endif
endmodule

// File: tb/tb_ahbl_slave_decoder.sv
// tb_ahbl_slave_decoder: scoreboard bench for ahbl_slave_decoder (counter checks when AHBL_DEC_ERR_CNT_EN is defined).
module tb_ahbl_slave_decoder;
    localparam logic [127:0] BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [127:0] MASK = {4{32'hF000_0000}};
    localparam logic [127:0] MASK_OV = {{3{32'hF000_0000}}, 32'h0000_0000};
    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [31:0] D0 = 32'hDA7A_0000, D1 = 32'hDA7A_0001, D2 = 32'hDA7A_0002, D3 = 32'hDA7A_0003;

    typedef struct packed {
        logic rdy;
        logic resp;
        logic [31:0] data;
    } exp_t;

    logic HCLK = 1'b0, HRESET;
    logic [31:0] HADDR;
    logic [1:0] HTRANS;
    logic [3:0] HSEL, HREADYOUT_S, HRESP_S, ov_hsel;
    logic [127:0] HRDATA_S = {D3, D2, D1, D0};
    logic HREADY, HRESP, ov_hready, ov_hresp;
    logic [31:0] HRDATA, ov_hrdata;
`ifdef AHBL_DEC_ERR_CNT_EN
    logic [15:0] DEC_ERR_COUNT, ov_cnt;
`endif
    exp_t sb[$];
    int n_chk = 0, n_err = 0;

    always #5 HCLK = ~HCLK;

    ahbl_slave_decoder #(.NS(4), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HSEL(HSEL),
        .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .HRDATA_S(HRDATA_S),
        .HREADY(HREADY), .HRESP(HRESP),
`ifdef AHBL_DEC_ERR_CNT_EN
        .DEC_ERR_COUNT(DEC_ERR_COUNT),
`endif
        .HRDATA(HRDATA)
    );

    ahbl_slave_decoder #(.NS(4), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK_OV)) dut_ov (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HSEL(ov_hsel),
        .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .HRDATA_S(HRDATA_S),
        .HREADY(ov_hready), .HRESP(ov_hresp),
`ifdef AHBL_DEC_ERR_CNT_EN
        .DEC_ERR_COUNT(ov_cnt),
`endif
        .HRDATA(ov_hrdata)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Drive one address phase, compare the current data phase against the queued expectation,
    // then queue what the next data phase should return.
    task automatic step(input logic [31:0] a, input logic [1:0] t, input logic [3:0] ro, input logic [3:0] rs,
                        input logic [3:0] hs, input logic erdy, input logic eresp, input logic [31:0] edata);
        exp_t e;
        HADDR = a;
        HTRANS = t;
        HREADYOUT_S = ro;
        HRESP_S = rs;
        #1;
        check("hsel", {28'h0, HSEL}, {28'h0, hs});
        check("sb_level", sb.size(), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("hready", {31'h0, HREADY}, {31'h0, e.rdy});
            check("hresp", {31'h0, HRESP}, {31'h0, e.resp});
            check("hrdata", HRDATA, e.data);
        end
        sb.push_back('{erdy, eresp, edata});
        @(negedge HCLK);
    endtask

    initial begin
        HRESET = 1'b1;
        HADDR = 32'h2000_0040;
        HTRANS = NSEQ;
        HREADYOUT_S = 4'hF;
        HRESP_S = 4'h0;
        repeat (2) @(negedge HCLK);
        #1;
        check("rst_hready", {31'h0, HREADY}, 32'h1);
        check("rst_hresp", {31'h0, HRESP}, 32'h0);
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_hsel", {28'h0, HSEL}, 32'h4);
`ifdef AHBL_DEC_ERR_CNT_EN
        check("rst_cnt", {16'h0, DEC_ERR_COUNT}, 32'h0);
`endif
        HRESET = 1'b0;
        sb.push_back('{1'b1, 1'b0, 32'h0});
        step(32'h2000_0040, NSEQ, 4'hF, 4'h0, 4'b0100, 1'b1, 1'b0, D2);
        step(32'h1000_0000, NSEQ, 4'hF, 4'h0, 4'b0010, 1'b0, 1'b0, D1);
        step(32'h3000_0000, NSEQ, 4'b1101, 4'h0, 4'b1000, 1'b0, 1'b0, D1);
        step(32'h3000_0000, NSEQ, 4'b1101, 4'h0, 4'b1000, 1'b0, 1'b0, D1);
        step(32'h3000_0000, NSEQ, 4'b1101, 4'h0, 4'b1000, 1'b1, 1'b0, D1);
        step(32'h3000_0000, NSEQ, 4'hF, 4'h0, 4'b1000, 1'b1, 1'b0, D3);
        step(32'h8000_0000, NSEQ, 4'hF, 4'h0, 4'b0000, 1'b0, 1'b1, 32'h0);
        check("ov_hsel_unmapped", {28'h0, ov_hsel}, 32'h1);
        step(32'h0000_0010, NSEQ, 4'hF, 4'h0, 4'b0001, 1'b1, 1'b1, 32'h0);
        step(32'h0000_0010, NSEQ, 4'hF, 4'h0, 4'b0001, 1'b1, 1'b1, D0);
`ifdef AHBL_DEC_ERR_CNT_EN
        check("cnt_one", {16'h0, DEC_ERR_COUNT}, 32'h1);
`endif
        step(32'h8000_0000, IDLE, 4'hF, 4'b0001, 4'b0000, 1'b1, 1'b0, 32'h0);
        step(32'h8000_0000, SEQ, 4'hF, 4'h0, 4'b0000, 1'b0, 1'b1, 32'h0);
        step(32'h8000_0004, SEQ, 4'hF, 4'h0, 4'b0000, 1'b1, 1'b1, 32'h0);
        step(32'h8000_0004, SEQ, 4'hF, 4'h0, 4'b0000, 1'b0, 1'b1, 32'h0);
        step(32'h0000_0000, IDLE, 4'hF, 4'h0, 4'b0001, 1'b1, 1'b1, 32'h0);
        step(32'h3000_0000, NSEQ, 4'hF, 4'h0, 4'b1000, 1'b1, 1'b0, D3);
        step(32'h8000_0000, BUSY, 4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, 32'h0);
`ifdef AHBL_DEC_ERR_CNT_EN
        check("cnt_three", {16'h0, DEC_ERR_COUNT}, 32'h3);
`endif
        step(32'h8000_0000, NSEQ, 4'hF, 4'h0, 4'b0000, 1'b0, 1'b1, 32'h0);
        HRESET = 1'b1;
        step(32'h8000_0000, NSEQ, 4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, 32'h0);
        HRESET = 1'b0;
`ifdef AHBL_DEC_ERR_CNT_EN
        check("cnt_after_rst", {16'h0, DEC_ERR_COUNT}, 32'h0);
`endif
        step(32'h1000_0000, IDLE, 4'hF, 4'h0, 4'b0010, 1'b1, 1'b0, D1);
        check("ov_hsel_overlap", {28'h0, ov_hsel}, 32'h1);
`ifdef AHBL_DEC_ERR_CNT_EN
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
`endif
        step(32'h8000_0000, NSEQ, 4'hF, 4'h0, 4'b0000, 1'b0, 1'b1, 32'h0);
        step(32'h0000_0000, IDLE, 4'hF, 4'h0, 4'b0001, 1'b1, 1'b1, 32'h0);
        step(32'h0000_0000, IDLE, 4'hF, 4'h0, 4'b0001, 1'b1, 1'b0, D0);
        step(32'h0000_0000, IDLE, 4'hF, 4'h0, 4'b0001, 1'b1, 1'b0, D0);
`ifdef AHBL_DEC_ERR_CNT_EN
        check("cnt_saturated", {16'h0, DEC_ERR_COUNT}, 32'hFFFF);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ahbl_slave_decoder.md
# ahbl_slave_decoder

AHB-Lite slave-side address decoder and response multiplexer sitting between the arbitrated master bus (after the multi-master arbiter) and NS slaves. Decodes the address phase into one-hot HSEL, registers the selection into the data phase, and returns the selected slave's HREADYOUT/HRESP/HRDATA to the master. Unmapped accesses go to an internal default slave that issues the two-cycle AHB ERROR response.

## Interface
- NS, 4, number of slaves (1..16)
- SLAVE_BASE, {NS{32'h0}}, flattened base addresses, slave i at [i*32+:32]
- SLAVE_MASK, {NS{32'h0}}, flattened address masks, slave i at [i*32+:32]

- HCLK  input  1  bus clock; all state on rising edge
- HRESET  input  1  synchronous, active-high reset
- HADDR  input  32  address-phase address from master
- HTRANS  input  2  address-phase transfer type (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11)
- HSEL  output  NS  one-hot address-phase slave select (combinational)
- HREADYOUT_S  input  NS  per-slave ready
- HRESP_S  input  NS  per-slave response
- HRDATA_S  input  NS*32  per-slave read data, slave i at [i*32+:32]
- HREADY  output  1  muxed ready to master and all slaves
- HRESP  output  1  muxed response to master
- HRDATA  output  32  muxed read data to master
- DEC_ERR_COUNT  output  16  decode-error count (only with AHBL_DEC_ERR_CNT_EN)

## Operation
- Match i: (HADDR & SLAVE_MASK[i]) == SLAVE_BASE[i]. Lowest matching index wins; HSEL has at most one bit set. No match: HSEL = 0, default slave selected.
- HSEL driven regardless of HTRANS; slaves qualify with HTRANS and HREADY.
- Data-phase register (DSEL, NS-bit one-hot, plus DDEF flag, plus DACT = HTRANS[1]) loads only when HREADY = 1; holds otherwise.
- Data-phase mux: DSEL bit i set -> HREADY = HREADYOUT_S[i], HRESP = HRESP_S[i], HRDATA = HRDATA_S[i]. DDEF set -> default slave outputs, HRDATA = 0.
- Default slave FSM, states DS_OK, DS_ERR1, DS_ERR2:
  - DS_OK: HREADY=1, HRESP=0. If HREADY and no match and HTRANS is NONSEQ/SEQ -> DS_ERR1; else stay.
  - DS_ERR1: HREADY=0, HRESP=1; unconditionally -> DS_ERR2.
  - DS_ERR2: HREADY=1, HRESP=1; new unmapped NONSEQ/SEQ -> DS_ERR1, else -> DS_OK.
- Unmapped IDLE/BUSY: DDEF set, FSM stays DS_OK, zero-wait OKAY.

## Timing
- Reset (HRESET high at edge): DSEL=0, DDEF=1, DACT=0, FSM=DS_OK -> HREADY=1, HRESP=0, HRDATA=0, DEC_ERR_COUNT=0. Reset mid-transfer (including DS_ERR1) aborts; next cycle is reset state.
- HSEL: zero-latency combinational from HADDR.
- Data phase begins the cycle after the address phase is accepted (HREADY=1); outputs combinational from registered select and slave inputs.
- Slave wait states: HREADY low holds DSEL/DDEF; new address phase is not sampled.
- Error response: exactly 2 cycles (ERR1 then ERR2); address presented during ERR1 is not accepted; address presented during ERR2 is accepted.
- Back-to-back mapped transfers to different slaves: each data phase muxes the slave from the preceding accepted address phase.

## Configuration
- AHBL_DEC_ERR_CNT_EN defined: DEC_ERR_COUNT port present; 16-bit counter increments on each DS_OK/DS_ERR2 -> DS_ERR1 transition, saturates at 16'hFFFF, cleared only by HRESET.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset: HRESET high 2 cycles -> HREADY=1, HRESP=0, HRDATA=0, HSEL follows HADDR decode, DEC_ERR_COUNT=0.
- NS=4, base 0x0000_0000/0x1000_0000/0x2000_0000/0x3000_0000, mask 0xF000_0000: NONSEQ to 0x2000_0040 -> HSEL=4'b0100; next cycle HRDATA=HRDATA_S slave 2, HREADY=HREADYOUT_S[2].
- Slave 1 holds HREADYOUT low 3 cycles while new address 0x3000_0000 presented -> HREADY low 3 cycles, data phase stays on slave 1, slave 3 data phase starts after HREADY high.
- NONSEQ to 0x8000_0000 -> HSEL=0; next two cycles HREADY/HRESP = 0/1 then 1/1; DEC_ERR_COUNT=1.
- IDLE to 0x8000_0000 -> HREADY=1, HRESP=0 next cycle, count unchanged.
- Overlapping map (slave 0 mask 0x0, base 0) -> address 0x1000_0000 selects slave 0 (lowest index wins); counter forced to 0xFFFF then one more error -> stays 0xFFFF.
